// File: rtl/emotion_update_scheduler.sv
// Tick-paced round-robin scheduler that applies +/-1 updates to one shared, saturating level register.
// Optional feature: define LEVEL_DECAY_EN so that a tick with no requests decays the level by one.
module emotion_update_scheduler #(
    parameter int                 WIDTH       = 8,
    parameter int                 TICK_DIV    = 16,
    parameter logic [WIDTH-1:0]   RESET_LEVEL = WIDTH'(8'h80)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       dir,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       indicator,
    output logic             sat
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    typedef enum logic {IDLE, APPLY} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic             dir_q, dir_d;
    logic             decay_q, decay_d;
    logic [WIDTH-1:0] level_q, level_d;

    logic             tick;
    logic             rr_hit;
    logic [1:0]       rr_idx;
    logic [1:0]       cand;
    logic [WIDTH:0]   step_res;

    // Returns {clipped, next_level} for a single +/-1 step that saturates at both ends.
    function automatic logic [WIDTH:0] sat_step(input logic [WIDTH-1:0] lvl, input logic up);
        if (up) begin
            if (&lvl) return {1'b1, lvl};
            return {1'b0, lvl + WIDTH'(1)};
        end
        if (lvl == '0) return {1'b1, lvl};
        return {1'b0, lvl - WIDTH'(1)};
    endfunction

    assign tick = (cnt_q == TICK_LAST);

    always_comb begin
        rr_hit = 1'b0;
        rr_idx = ptr_q;
        cand   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!rr_hit && req[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? 8'd0 : cnt_q + 8'd1;
        ptr_d    = ptr_q;
        win_d    = win_q;
        dir_d    = dir_q;
        decay_d  = decay_q;
        level_d  = level_q;
        grant    = 4'b0000;
        sat      = 1'b0;
        step_res = sat_step(level_q, dir_q);
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (rr_hit) begin
                        win_d   = rr_idx;
                        dir_d   = dir[rr_idx];
                        decay_d = 1'b0;
                        state_d = APPLY;
                    end else begin
`ifdef LEVEL_DECAY_EN
                        decay_d = 1'b1;
                        state_d = APPLY;
`else
                        decay_d = 1'b0;
`endif
                    end
                end
            end
            APPLY: begin
                state_d = IDLE;
                if (decay_q) begin
                    // Decay is silent: no grant, no clip flag, arbitration pointer untouched.
                    level_d = (level_q == '0) ? level_q : level_q - WIDTH'(1);
                end else begin
                    level_d     = step_res[WIDTH-1:0];
                    grant[win_q] = 1'b1;
                    sat         = step_res[WIDTH];
                    ptr_d       = win_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset landing on the APPLY cycle must suppress the acknowledge as well as the update.
        if (rst) begin
            grant = 4'b0000;
            sat   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ptr_q   <= 2'd3;
            decay_q <= 1'b0;
            level_q <= RESET_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            decay_q <= decay_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
        dir_q <= dir_d;
    end

    assign level     = level_q;
    assign indicator = level_q[WIDTH-1 -: 2];

endmodule
